// File: rtl/unpack_rx.sv
// unpack_rx: receive-side frame parser for the packed byte stream.
//
// Consumes bytes (pk_data qualified by pk_vld inside the pk_frm envelope),
// recovers the header (cfg_sample, len, utc, ns), re-emits 24-bit x/y/z
// samples and checks sync, length, framing and the mod-256 checksum.
//
// Ports:
//   clk_sys, rst               clock, synchronous active-high reset
//   pk_data/pk_vld/pk_frm      packed byte stream in
//   hdr_sample/len/utc/ns      header fields, updated with hdr_vld pulse
//   smp_x/y/z, smp_idx         sample out, qualified by smp_vld pulse
//   frm_done / frm_err         one pulse per frame, one cycle after pk_frm low
//   err_code                   first error of the frame, held until next start
//   frm_cnt / err_cnt          saturating good/bad frame counters
module unpack_rx #(
  parameter logic [11:0] MAX_LEN = 12'd512,
  parameter logic [7:0]  SYNC0   = 8'hAA,
  parameter logic [7:0]  SYNC1   = 8'h55
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  pk_data,
  input  logic        pk_vld,
  input  logic        pk_frm,
  output logic [7:0]  hdr_sample,
  output logic [11:0] hdr_len,
  output logic [31:0] hdr_utc,
  output logic [31:0] hdr_ns,
  output logic        hdr_vld,
  output logic [23:0] smp_x,
  output logic [23:0] smp_y,
  output logic [23:0] smp_z,
  output logic [11:0] smp_idx,
  output logic        smp_vld,
  output logic        frm_done,
  output logic        frm_err,
  output logic [2:0]  err_code,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, HEAD, LOAD, TAIL, TWAIT, DROP} state_t;

  state_t      state;
  logic        frm_prev;
  logic [3:0]  hcnt;       // header byte index
  logic [3:0]  gcnt;       // byte index within a 9-byte sample group
  logic [11:0] scnt;       // samples emitted in this frame
  logic [7:0]  csum;
  logic [7:0]  sample_sh;
  logic [7:0]  len_hi;
  logic [11:0] len_sh;
  logic [31:0] utc_sh;
  logic [31:0] ns_sh;
  logic [63:0] grp;        // first 8 bytes of the current sample group

  logic        take;
  logic        rise;
  logic [15:0] len_word;
  logic        len_bad;

  assign take     = pk_vld & pk_frm;
  assign rise     = pk_frm & ~frm_prev;
  assign len_word = {len_hi, pk_data};
  assign len_bad  = (len_word[15:12] != 4'd0) || (len_word[11:0] > MAX_LEN);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame parser FSM with registered outputs and counters.
  always_ff @(posedge clk_sys) begin
    // Tracked through reset so a frame already in flight at release is not
    // mistaken for a new start.
    frm_prev <= pk_frm;
    if (rst) begin
      state      <= IDLE;
      hcnt       <= 4'd0;
      gcnt       <= 4'd0;
      scnt       <= 12'd0;
      csum       <= 8'd0;
      sample_sh  <= 8'd0;
      len_hi     <= 8'd0;
      len_sh     <= 12'd0;
      utc_sh     <= 32'd0;
      ns_sh      <= 32'd0;
      grp        <= 64'd0;
      hdr_sample <= 8'd0;
      hdr_len    <= 12'd0;
      hdr_utc    <= 32'd0;
      hdr_ns     <= 32'd0;
      hdr_vld    <= 1'b0;
      smp_x      <= 24'd0;
      smp_y      <= 24'd0;
      smp_z      <= 24'd0;
      smp_idx    <= 12'd0;
      smp_vld    <= 1'b0;
      frm_done   <= 1'b0;
      frm_err    <= 1'b0;
      err_code   <= 3'd0;
      frm_cnt    <= 16'd0;
      err_cnt    <= 16'd0;
    end else begin
      hdr_vld  <= 1'b0;
      smp_vld  <= 1'b0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            err_code <= 3'd0;
            csum     <= 8'd0;
            hcnt     <= 4'd0;
            gcnt     <= 4'd0;
            scnt     <= 12'd0;
            // B0 may arrive in the very cycle the envelope rises.
            if (take) begin
              if (pk_data == SYNC0) begin
                hcnt  <= 4'd1;
                state <= HEAD;
              end else begin
                err_code <= 3'd1;
                state    <= DROP;
              end
            end else begin
              state <= HEAD;
            end
          end
        end
        HEAD: begin
          if (!pk_frm) begin
            err_code <= 3'd3;
            frm_err  <= 1'b1;
            err_cnt  <= sat_inc(err_cnt);
            state    <= IDLE;
          end else if (take) begin
            hcnt <= hcnt + 4'd1;
            if (hcnt >= 4'd2) csum <= csum + pk_data;
            case (hcnt)
              4'd0: if (pk_data != SYNC0) begin
                err_code <= 3'd1;
                state    <= DROP;
              end
              4'd1: if (pk_data != SYNC1) begin
                err_code <= 3'd1;
                state    <= DROP;
              end
              4'd2: sample_sh <= pk_data;
              4'd3: len_hi <= pk_data;
              4'd4: begin
                if (len_bad) begin
                  err_code <= 3'd2;
                  state    <= DROP;
                end else begin
                  len_sh <= len_word[11:0];
                end
              end
              4'd5, 4'd6, 4'd7, 4'd8: utc_sh <= {utc_sh[23:0], pk_data};
              4'd9, 4'd10, 4'd11:     ns_sh  <= {ns_sh[23:0], pk_data};
              4'd12: begin
                hdr_sample <= sample_sh;
                hdr_len    <= len_sh;
                hdr_utc    <= utc_sh;
                hdr_ns     <= {ns_sh[23:0], pk_data};
                hdr_vld    <= 1'b1;
                state      <= (len_sh == 12'd0) ? TAIL : LOAD;
              end
              default: begin
              end
            endcase
          end
        end
        LOAD: begin
          if (!pk_frm) begin
            err_code <= 3'd3;
            frm_err  <= 1'b1;
            err_cnt  <= sat_inc(err_cnt);
            state    <= IDLE;
          end else if (take) begin
            csum <= csum + pk_data;
            if (gcnt == 4'd8) begin
              smp_x   <= grp[63:40];
              smp_y   <= grp[39:16];
              smp_z   <= {grp[15:0], pk_data};
              smp_idx <= scnt;
              smp_vld <= 1'b1;
              scnt    <= scnt + 12'd1;
              gcnt    <= 4'd0;
              if (scnt + 12'd1 == len_sh) state <= TAIL;
            end else begin
              grp  <= {grp[55:0], pk_data};
              gcnt <= gcnt + 4'd1;
            end
          end
        end
        TAIL: begin
          if (!pk_frm) begin
            err_code <= 3'd3;
            frm_err  <= 1'b1;
            err_cnt  <= sat_inc(err_cnt);
            state    <= IDLE;
          end else if (take) begin
            if (pk_data != csum) err_code <= 3'd5;
            state <= TWAIT;
          end
        end
        TWAIT: begin
          if (!pk_frm) begin
            if (err_code == 3'd0) begin
              frm_done <= 1'b1;
              frm_cnt  <= sat_inc(frm_cnt);
            end else begin
              frm_err <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
            end
            state <= IDLE;
          end else if (take && (err_code == 3'd0)) begin
            err_code <= 3'd4;
          end
        end
        DROP: begin
          if (!pk_frm) begin
            frm_err <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
